// File: rtl/i2c_eeprom_slave.sv
// i2c_eeprom_slave: 128-byte I2C EEPROM responder on clk_250KHz.
// SCL/SDA are oversampled through 2-flop synchronizers plus an edge register.
// Optional write protect input `wp` when I2C_SLAVE_WP_EN is defined.
module i2c_eeprom_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h53,
  parameter logic [7:0] MEM_INIT   = 8'hFF
) (
  input  logic       clk_250KHz,
  input  logic       sys_rst_n,
  input  logic       scl,
  input  logic       sda_in,
`ifdef I2C_SLAVE_WP_EN
  input  logic       wp,
`endif
  output logic       sda_low,
  output logic       wr_en,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] DEV_ADDR  = 4'd1;
  localparam logic [3:0] DEV_ACK   = 4'd2;
  localparam logic [3:0] WORD_ADDR = 4'd3;
  localparam logic [3:0] WORD_ACK  = 4'd4;
  localparam logic [3:0] WR_DATA   = 4'd5;
  localparam logic [3:0] WR_ACK    = 4'd6;
  localparam logic [3:0] RD_DATA   = 4'd7;
  localparam logic [3:0] RD_ACK    = 4'd8;
  localparam logic [3:0] WAIT_STOP = 4'd9;

  logic [2:0] scl_sync_q, sda_sync_q;
  logic       wp_s;

  logic [3:0] state_q,   state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q,   shift_d;
  logic [6:0] ptr_q,     ptr_d;
  logic       rw_q,      rw_d;
  logic       ack_ph_q,  ack_ph_d;
  logic       sda_low_q, sda_low_d;
  logic       busy_q,    busy_d;
  logic       wr_en_q,   wr_en_d;
  logic [6:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       mem_we;

  // Storage is deliberately outside the reset domain: contents survive sys_rst_n.
  logic [7:0] mem_q [0:127] = '{default: MEM_INIT};

  logic       rise, fall, start_ev, stop_ev, sda_s;
  logic [7:0] byte_in, rd_cur, rd_next;
  logic [6:0] ptr_inc;

  // Bus input synchronizers; reset to the idle-high bus level so release makes no edges.
  always_ff @(posedge clk_250KHz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[1:0], scl};
      sda_sync_q <= {sda_sync_q[1:0], sda_in};
    end
  end

`ifdef I2C_SLAVE_WP_EN
  logic [1:0] wp_sync_q;
  // Write-protect synchronizer, same depth as the bus inputs.
  always_ff @(posedge clk_250KHz or negedge sys_rst_n) begin
    if (!sys_rst_n) wp_sync_q <= '0;
    else            wp_sync_q <= {wp_sync_q[0], wp};
  end
  assign wp_s = wp_sync_q[1];
`else
  assign wp_s = 1'b0;
`endif

  assign sda_s    = sda_sync_q[1];
  assign rise     =  scl_sync_q[1] & ~scl_sync_q[2];
  assign fall     = ~scl_sync_q[1] &  scl_sync_q[2];
  assign start_ev =  scl_sync_q[1] &  scl_sync_q[2] & ~sda_sync_q[1] &  sda_sync_q[2];
  assign stop_ev  =  scl_sync_q[1] &  scl_sync_q[2] &  sda_sync_q[1] & ~sda_sync_q[2];

  assign byte_in  = {shift_q[6:0], sda_s};
  assign ptr_inc  = ptr_q + 7'd1;
  assign rd_cur   = mem_q[ptr_q];
  assign rd_next  = mem_q[ptr_inc];

  // Protocol FSM: START/STOP take priority over any SCL edge seen in the same cycle.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    ack_ph_d  = ack_ph_q;
    sda_low_d = sda_low_q;
    busy_d    = busy_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    mem_we    = 1'b0;

    if (start_ev) begin
      state_d   = DEV_ADDR;
      bit_cnt_d = '0;
      ack_ph_d  = 1'b0;
      sda_low_d = 1'b0;
    end else if (stop_ev) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      ack_ph_d  = 1'b0;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        DEV_ADDR, WORD_ADDR, WR_DATA: begin
          if (rise) begin
            shift_d = byte_in;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              if (state_q == DEV_ADDR) begin
                if (byte_in[7:1] == SLAVE_ADDR) begin
                  rw_d    = byte_in[0];
                  busy_d  = 1'b1;
                  state_d = DEV_ACK;
                end else begin
                  state_d = WAIT_STOP;
                end
              end else if (state_q == WORD_ADDR) begin
                ptr_d   = byte_in[6:0];
                state_d = WORD_ACK;
              end else if (wp_s) begin
                state_d = WAIT_STOP;
              end else begin
                mem_we    = 1'b1;
                wr_en_d   = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = byte_in;
                ptr_d     = ptr_inc;
                state_d   = WR_ACK;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        // ACK slot: first fall pulls SDA low, second fall releases and moves on.
        DEV_ACK, WORD_ACK, WR_ACK: begin
          if (fall) begin
            if (!ack_ph_q) begin
              ack_ph_d  = 1'b1;
              sda_low_d = 1'b1;
            end else begin
              ack_ph_d  = 1'b0;
              sda_low_d = 1'b0;
              bit_cnt_d = '0;
              if (state_q == DEV_ACK && rw_q) begin
                // Bit 7 goes out on the same fall that ends the ACK slot.
                sda_low_d = ~rd_cur[7];
                shift_d   = {rd_cur[6:0], 1'b0};
                bit_cnt_d = 4'd1;
                state_d   = RD_DATA;
              end else if (state_q == DEV_ACK) begin
                state_d = WORD_ADDR;
              end else begin
                state_d = WR_DATA;
              end
            end
          end
        end
        RD_DATA: begin
          if (fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_low_d = 1'b0;
              bit_cnt_d = '0;
              state_d   = RD_ACK;
            end else begin
              sda_low_d = ~shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        RD_ACK: begin
          if (rise) begin
            if (!sda_s) begin
              ptr_d     = ptr_inc;
              shift_d   = rd_next;
              bit_cnt_d = '0;
              state_d   = RD_DATA;
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Control and output registers.
  always_ff @(posedge clk_250KHz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      ack_ph_q  <= 1'b0;
      sda_low_q <= 1'b0;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      ack_ph_q  <= ack_ph_d;
      sda_low_q <= sda_low_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Memory write port.
  always_ff @(posedge clk_250KHz) begin
    if (mem_we) mem_q[ptr_q] <= byte_in;
  end

  assign sda_low = sda_low_q;
  assign busy    = busy_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: doc/i2c_eeprom_slave.md
# i2c_eeprom_slave

- Responder end of the team's two-wire EEPROM bus: a 128-byte I2C slave that answers the bus master's byte/page writes and random/sequential reads.
- Oversamples SCL and SDA on clk_250KHz, detects START/STOP, ACKs its own address, and drives SDA open-drain.
- Serves as both the on-chip EEPROM stand-in and the bench responder for the master.

## Interface
- SLAVE_ADDR, 7'h53: 7-bit device address matched after START.
- MEM_INIT, 8'hFF: content of every memory byte at time zero. The memory array is not reset.
- clk_250KHz  input  1  system clock for all logic.
- sys_rst_n  input  1  reset, asynchronous, active-low; clock clk_250KHz.
- scl  input  1  bus clock from the master, asynchronous.
- sda_in  input  1  sampled bus data, asynchronous.
- sda_low  output  1  1 = pull SDA low; 0 = release (high-Z at pad).
- wr_en  output  1  one-cycle pulse per byte committed to memory.
- wr_addr  output  7  memory index of the committed byte.
- wr_data  output  8  value of the committed byte.
- busy  output  1  high from address match to STOP/abort.

## Operation
- Inputs pass through 2-flop synchronizers, then a third register for edge detection.
- Bus events:
  - rise/fall = SCL edge.
  - START = SDA 1→0 while SCL high.
  - STOP = SDA 0→1 while SCL high.
- States: IDLE, DEV_ADDR, DEV_ACK, WORD_ADDR, WORD_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- START in any state → DEV_ADDR with bit_cnt=0. This also covers repeated START.
- STOP in any state → IDLE with sda_low=0 and busy=0.
- Bit sampling: data is sampled on rise, MSB first. bit_cnt is 4 bits and counts 0..7. The 8th rise completes a byte.
- DEV_ADDR, byte complete:
  - addr[7:1]==SLAVE_ADDR → DEV_ACK.
  - Otherwise → WAIT_STOP; never drives.
- DEV_ACK, on the next fall: sda_low=1 for one SCL period. On the fall after that, sda_low is released.
  - R/W=0 → WORD_ADDR.
  - R/W=1 → RD_DATA; shifter loads mem[ptr] and bit 7 is driven immediately.
- WORD_ADDR: byte complete → ptr = byte[6:0] (bit 7 ignored), then ACK → WR_DATA.
- WR_DATA: byte complete → mem[ptr] written; wr_en pulses with wr_addr=ptr and wr_data=byte; ptr increments; ACK → WR_DATA.
- RD_DATA: on each fall, sda_low = ~shift[7] and the shifter moves left. After 8 bits, SDA is released → RD_ACK.
- RD_ACK: master bit sampled on rise.
  - 0 → ptr increments, mem[ptr] is loaded, → RD_DATA.
  - 1 → WAIT_STOP.
- Pointer is 7 bits and wraps 127→0 for both reads and writes. There is no page boundary.
- Simultaneous rise and START/STOP in the same cycle: START/STOP wins; the bit is discarded.

## Timing
- Input→internal event latency: 3 clk_250KHz cycles.
- SDA changes only 1 cycle after a detected fall, which keeps hold time off the SCL high phase.
- SCL high and low phases must each be ≥4 clk_250KHz cycles, i.e. SCL ≤ 31.25 kHz at the nominal clock. Faster SCL is unsupported.
- wr_en asserts 1 cycle after the 8th data-bit rise is detected, which is before the ACK is driven.
- Reset values: sda_low=0, wr_en=0, wr_addr=0, wr_data=0, busy=0. State=IDLE, ptr=0, bit_cnt=0.
- Reset mid-transfer releases SDA within the same cycle (asynchronous). Partial bytes are lost; committed bytes are kept.

## Configuration
- Macro I2C_SLAVE_WP_EN adds input `wp` (1 bit, synchronized like the bus inputs).
  - With the macro and wp=1: WR_DATA bytes are NACKed (SDA released in the ACK slot), no write and no wr_en, state → WAIT_STOP. Address bytes are still ACKed.
  - With the macro and wp=0: behaviour is identical to the build without it.
  - Without the macro: no `wp` port; every write is accepted.

## Test plan
- Byte write: START, 0xA6, 0x05, 0x3C, STOP → ACK on all 3 bytes; one wr_en with wr_addr=0x05, wr_data=0x3C; busy falls at STOP.
- Page write with wrap: word 0x7E, then data 0x11, 0x22, 0x33 → mem[0x7E]=0x11, mem[0x7F]=0x22, mem[0x00]=0x33; 3 wr_en pulses.
- Random + sequential read: write 0x10=0xA5, 0x11=0x5A; then START 0xA6 0x10, repeated START 0xA7, master ACK then NACK → SDA bytes 0xA5, 0x5A; then WAIT_STOP with SDA released.
- Address mismatch: START 0xA8 … STOP → sda_low stays 0 throughout; busy stays 0; no wr_en.
- Reset mid-byte: assert sys_rst_n low during the 4th data bit of a write → sda_low=0 immediately; earlier committed bytes are retained; the next full transaction succeeds.
- With I2C_SLAVE_WP_EN, wp=1: write 0x20=0x99 → device and word ACKed, data NACKed, no wr_en; a read of 0x20 returns the prior value.
